// File: rtl/sp_rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: request handshake, response handshake
// and the shared response data word. The arbiter takes the slave view, and the
// client blocks (or a testbench) take the master view.
interface sp_rom_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int N_REQ  = 2
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]       resp_rdata;
   logic [N_REQ-1:0]        resp_ready;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/sp_rom_arbiter.sv
// Round-robin arbiter sharing one single-port ROM (1-cycle read latency)
// between N_REQ read requesters. At most one read is outstanding at a time.
// A new read can be issued in the same cycle that the held response is
// consumed, which gives one read every two cycles when responses are taken
// immediately.
module sp_rom_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int N_REQ  = 2
) (
   input  logic              clk,
   input  logic              rst,
   sp_rom_arbiter_if.slave   bus,
   output logic              rom_r_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_rdata
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  tag;
   logic [N_REQ-1:0]  resp_valid_q;
   logic [DATA_W-1:0] resp_rdata_q;

   logic              fire;
   logic              issue_ok;
   logic              grant;
   logic [PTR_W-1:0]  win;
   logic [ADDR_W-1:0] win_addr;
   logic [PTR_W-1:0]  ptr_next;
   logic [N_REQ-1:0]  tag_onehot;
   logic [N_REQ-1:0]  ready_vec;

   assign fire     = (state == RESP) && (|(resp_valid_q & bus.resp_ready));
   assign issue_ok = !rst && ((state == IDLE) || fire);

   // Round-robin search from ptr upward (wrapping); the first pending request wins.
   always_comb begin
      logic found;
      found    = 1'b0;
      win      = '0;
      win_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         int idx;
         idx = (int'(ptr) + i) % N_REQ;
         if (!found && bus.req_valid[PTR_W'(idx)]) begin
            found    = 1'b1;
            win      = PTR_W'(idx);
            win_addr = bus.req_addr[idx*ADDR_W +: ADDR_W];
         end
      end
      grant = found && issue_ok;
   end

   // Issue-cycle outputs toward the requesters and the ROM, plus the next pointer.
   always_comb begin
      ready_vec  = '0;
      tag_onehot = '0;
      ptr_next   = ptr;
      if (grant) begin
         ready_vec[win] = 1'b1;
         ptr_next       = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
      tag_onehot[tag] = 1'b1;
   end

   assign bus.req_ready  = ready_vec;
   assign rom_r_en       = grant;
   assign rom_addr       = grant ? win_addr : '0;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;

   // Control FSM: issue in IDLE (or RESP on fire), wait one cycle for the ROM, hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         tag          <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  ptr   <= ptr_next;
                  tag   <= win;
                  state <= READ;
               end
            end
            READ: begin
               resp_rdata_q <= rom_rdata;
               resp_valid_q <= tag_onehot;
               state        <= RESP;
            end
            RESP: begin
               if (fire) begin
                  resp_valid_q <= '0;
                  if (grant) begin
                     ptr   <= ptr_next;
                     tag   <= win;
                     state <= READ;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               resp_valid_q <= '0;
            end
         endcase
      end
   end

endmodule
